// File: rtl/transposed_filter_pkg.sv
// Shared constants for the 8-tap transposed-form low-pass FIR.
// Coefficients are Q1.17 and sum to 2^17, so the DC gain is one.
package transposed_filter_pkg;

    localparam int DATA_W      = 18;
    localparam int COEF_W      = 18;
    localparam int NTAPS       = 8;
    localparam int ACC_W       = DATA_W + COEF_W + $clog2(NTAPS);
    localparam int ROUND_SHIFT = 17;

    // Symmetric low-pass taps, c0..c7.
    localparam logic signed [COEF_W-1:0] COEFS [NTAPS] = '{
        18'sd2048, 18'sd8192, 18'sd20480, 18'sd34816,
        18'sd34816, 18'sd20480, 18'sd8192, 18'sd2048
    };

    // Half an output LSB, added before the shift for round-half-up.
    localparam logic signed [ACC_W-1:0] ROUND_ADD =
        {{(ACC_W-ROUND_SHIFT){1'b0}}, 1'b1, {(ROUND_SHIFT-1){1'b0}}};

    // Output clamp limits, expressed at shifted-accumulator width.
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

endpackage

// File: rtl/transposed_filter_tap.sv
// One transposed-form stage: r_out <= coef*x + r_in while enabled.
module transposed_filter_tap
    import transposed_filter_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_en,
    input  logic signed [DATA_W-1:0] i_x,
    input  logic signed [COEF_W-1:0] i_coef,
    input  logic signed [ACC_W-1:0]  i_r,
    output logic signed [ACC_W-1:0]  o_r
);

    logic signed [DATA_W+COEF_W-1:0] w_prod;
    logic signed [ACC_W-1:0]         w_prod_ext;
    logic signed [ACC_W-1:0]         r_sum;

    assign w_prod     = i_x * i_coef;
    assign w_prod_ext = {{(ACC_W-DATA_W-COEF_W){w_prod[DATA_W+COEF_W-1]}}, w_prod};

    // Partial sum advances only on accepted samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_sum <= '0;
        else if (i_en)
            r_sum <= w_prod_ext + i_r;
    end

    assign o_r = r_sum;

endmodule

// File: rtl/transposed_filter.sv
// Transposed-form FIR low-pass filter, 18-bit signed in/out, one output
// per accepted sample, one cycle after the sampling edge.
// Build option: define TRANSPOSED_FILTER_SAT_EN to clamp the scaled result
// to the 18-bit signed range; otherwise the result wraps to 18 bits.
module transposed_filter
    import transposed_filter_pkg::*;
(
    input  logic              Clk_i,
    input  logic              Rst_n_i,
    input  logic [DATA_W-1:0] Data_i,
    input  logic              DataNd_i,
    output logic [DATA_W-1:0] Data_o,
    output logic              DataValid_o
);

    logic signed [DATA_W-1:0]        w_x;
    logic signed [ACC_W-1:0]         w_r [NTAPS];
    logic signed [DATA_W+COEF_W-1:0] w_prod0;
    logic signed [ACC_W-1:0]         w_acc;
    logic signed [ACC_W-1:0]         w_sum;
    logic signed [ACC_W-1:0]         w_shift;
    logic        [DATA_W-1:0]        w_scaled;
    logic        [DATA_W-1:0]        r_data;
    logic                            r_valid;

    assign w_x = $signed(Data_i);

    // The register past the last tap does not exist: feed zero.
    assign w_r[NTAPS-1] = '0;

    genvar k;
    generate
        for (k = 0; k < NTAPS-1; k++) begin : g_tap
            transposed_filter_tap u_tap (
                .clk    (Clk_i),
                .rst_n  (Rst_n_i),
                .i_en   (DataNd_i),
                .i_x    (w_x),
                .i_coef (COEFS[k+1]),
                .i_r    (w_r[k+1]),
                .o_r    (w_r[k])
            );
        end
    endgenerate

    // Tap 0 is combinational: it forms the full sum for the current sample.
    assign w_prod0 = w_x * COEFS[0];
    assign w_acc   = {{(ACC_W-DATA_W-COEF_W){w_prod0[DATA_W+COEF_W-1]}}, w_prod0} + w_r[0];
    assign w_sum   = w_acc + ROUND_ADD;
    assign w_shift = w_sum >>> ROUND_SHIFT;

`ifdef TRANSPOSED_FILTER_SAT_EN
    // Clamp to the representable output range.
    always_comb begin
        w_scaled = w_shift[DATA_W-1:0];
        if (w_shift > SAT_MAX)
            w_scaled = SAT_MAX[DATA_W-1:0];
        else if (w_shift < SAT_MIN)
            w_scaled = SAT_MIN[DATA_W-1:0];
    end
`else
    // Keep the low bits; with the fixed coefficients this never wraps.
    assign w_scaled = w_shift[DATA_W-1:0];
`endif

    // Output register: new value and a one-cycle valid per accepted sample.
    always_ff @(posedge Clk_i or negedge Rst_n_i) begin
        if (!Rst_n_i) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= DataNd_i;
            if (DataNd_i)
                r_data <= w_scaled;
        end
    end

    assign Data_o      = r_data;
    assign DataValid_o = r_valid;

endmodule

// File: tb/tb_transposed_filter.sv
// Scoreboard bench: stimulus pushes hand-computed outputs, a negedge
// monitor pops and compares on every DataValid_o pulse.
module tb_transposed_filter;

    logic        Clk_i = 1'b0;
    logic        Rst_n_i = 1'b0;
    logic [17:0] Data_i = '0;
    logic        DataNd_i = 1'b0;
    logic [17:0] Data_o;
    logic        DataValid_o;

    int q[$];
    int checks = 0;
    int failures = 0;
    int last_o = 0;

    int sp[8] = '{2048, 10240, 30720, 65536, 100351, 120831, 129023, 131071};
    int sn[8] = '{-2048, -10240, -30720, -65536, -100352, -120832, -129024, -131072};
    int imp[9] = '{2048, 8192, 20480, 34816, 34816, 20480, 8192, 2048, 0};

    transposed_filter dut (
        .Clk_i       (Clk_i),
        .Rst_n_i     (Rst_n_i),
        .Data_i      (Data_i),
        .DataNd_i    (DataNd_i),
        .Data_o      (Data_o),
        .DataValid_o (DataValid_o)
    );

    always #5 Clk_i = ~Clk_i;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: reset state, scoreboard pops, and hold between pulses.
    always @(negedge Clk_i) begin
        if (!Rst_n_i) begin
            chk("reset_data", int'($signed(Data_o)), 0);
            chk("reset_valid", int'(DataValid_o), 0);
            last_o = 0;
            q.delete();
        end else if (DataValid_o) begin
            if (q.size() == 0) begin
                chk("unexpected_valid", int'($signed(Data_o)), 999999);
            end else begin
                int e;
                e = q.pop_front();
                chk("data", int'($signed(Data_o)), e);
            end
            last_o = int'($signed(Data_o));
        end else begin
            chk("hold", int'($signed(Data_o)), last_o);
        end
    end

    task automatic send(input logic [17:0] x, input bit nd, input int exp);
        @(posedge Clk_i);
        #1;
        Data_i   = x;
        DataNd_i = nd;
        if (nd) q.push_back(exp);
    endtask

    // Idle a cycle so the last output is observed, then reset with busy inputs.
    task automatic do_reset();
        send(18'h0, 1'b0, 0);
        @(posedge Clk_i);
        #1;
        Rst_n_i  = 1'b0;
        DataNd_i = 1'b1;
        Data_i   = 18'h1FFFF;
        repeat (2) @(posedge Clk_i);
        #1;
        Rst_n_i  = 1'b1;
        DataNd_i = 1'b0;
        Data_i   = 18'h0;
    endtask

    initial begin
        // Reset held with toggling inputs.
        for (int i = 0; i < 4; i++) begin
            @(posedge Clk_i);
            #1;
            Data_i   = 18'($urandom);
            DataNd_i = i[0];
        end
        // Release with a zero sample strobed.
        @(posedge Clk_i);
        #1;
        Rst_n_i  = 1'b1;
        Data_i   = 18'h0;
        DataNd_i = 1'b1;
        q.push_back(0);
        send(18'h0, 1'b1, 0);
        send(18'h0, 1'b1, 0);

        // Impulse response.
        send(18'h1FFFF, 1'b1, imp[0]);
        for (int i = 1; i < 9; i++) send(18'h0, 1'b1, imp[i]);

        // Positive step, interrupted by reset after four samples.
        for (int i = 0; i < 4; i++) send(18'h1FFFF, 1'b1, sp[i]);
        do_reset();
        for (int i = 0; i < 11; i++) send(18'h1FFFF, 1'b1, sp[(i > 7) ? 7 : i]);

        // Negative full-scale step.
        do_reset();
        for (int i = 0; i < 11; i++) send(18'h20000, 1'b1, sn[(i > 7) ? 7 : i]);

        // Gapped positive step: junk on Data_i during gaps must be ignored.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            send(18'h1FFFF, 1'b1, sp[(i > 7) ? 7 : i]);
            send(18'h15555, 1'b0, 0);
        end

        // Drain with a bounded wait.
        DataNd_i = 1'b0;
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge Clk_i);
        @(negedge Clk_i);
        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
